// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: single-ported word memory behind a valid/ready request channel,
// with a fixed number of wait states, a flush input and a program-load write port.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic [31:0] i_ReqAddress,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic [31:0] o_RespData,
  output logic [31:0] o_RespAddress,
  output logic        o_RespError,
  input  logic        i_Flush,
  input  logic        i_WrEnable,
  input  logic [31:0] i_WrAddress,
  input  logic [31:0] i_WrData
);

  localparam int unsigned AddrBits = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  CntLoad  = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
  localparam logic [31:0] Nop      = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      stateQ, stateD;
  logic [2:0]  cntQ, cntD;
  logic [31:0] pendAddrQ, pendAddrD;
  logic [31:0] respDataQ, respAddrQ;
  logic        respErrQ;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        loadResp;
  logic [31:0] fetchAddr;
  logic        fetchErr;
  logic        wrOk;

  function automatic logic badAddr(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  // Ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    o_ReqReady  = 1'b0;
    o_RespValid = 1'b0;
    case (stateQ)
      StIdle: o_ReqReady = i_Reset_n;
      StResp: begin
        o_RespValid = 1'b1;
        o_ReqReady  = i_RespReady;
      end
      default: ;
    endcase
  end

  assign accept = i_ReqValid & o_ReqReady & ~i_Flush;

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    pendAddrD = pendAddrQ;
    loadResp  = 1'b0;
    fetchAddr = pendAddrQ;
    if (i_Flush) begin
      stateD = StIdle;
      cntD   = 3'd0;
    end else if (accept) begin
      pendAddrD = i_ReqAddress;
      if (WAIT_STATES == 0) begin
        stateD    = StResp;
        loadResp  = 1'b1;
        fetchAddr = i_ReqAddress;
      end else begin
        stateD = StWait;
        cntD   = CntLoad;
      end
    end else begin
      case (stateQ)
        StWait: begin
          if (cntQ == 3'd0) begin
            stateD   = StResp;
            loadResp = 1'b1;
          end else begin
            cntD = cntQ - 3'd1;
          end
        end
        StResp: if (i_RespReady) stateD = StIdle;
        default: ;
      endcase
    end
  end

  assign fetchErr = badAddr(fetchAddr);
  assign wrOk     = i_WrEnable & ~badAddr(i_WrAddress);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stateQ    <= StIdle;
      cntQ      <= 3'd0;
      pendAddrQ <= 32'd0;
      respDataQ <= 32'd0;
      respAddrQ <= 32'd0;
      respErrQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      pendAddrQ <= pendAddrD;
      // Read samples the old word, so a write on this same edge is not seen.
      if (loadResp) begin
        respAddrQ <= fetchAddr;
        respErrQ  <= fetchErr;
        respDataQ <= fetchErr ? Nop : mem[fetchAddr[AddrBits+1:2]];
      end
    end
  end

  // Memory has no reset so a loaded program survives a core reset.
  always_ff @(posedge i_Clock) begin
    if (wrOk) mem[i_WrAddress[AddrBits+1:2]] <= i_WrData;
  end

  assign o_RespData    = respDataQ;
  assign o_RespAddress = respAddrQ;
  assign o_RespError   = respErrQ;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (1 and 0 wait states) share stimulus and are
// compared every cycle against a transaction-level model with its own memory image.
module tb_instr_mem_responder;

  localparam int unsigned Depth0 = 1024;
  localparam int unsigned Depth1 = 64;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, respReady, flush, wrEn;
  logic [31:0] reqAddr, wrAddr, wrData;
  logic [1:0]  reqReady, respValid, respError;
  logic [31:0] respData [2];
  logic [31:0] respAddr [2];

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state
  logic [31:0] refMem [Depth0];
  bit          mBusy  [2];
  bit          mValid [2];
  int unsigned mDue   [2];
  logic [31:0] mPend  [2];
  logic [31:0] mData  [2];
  logic [31:0] mAddr  [2];
  bit          mErr   [2];
  int unsigned edgeNo = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(Depth0), .WAIT_STATES(1)) u_dut0 (
    .i_Clock(clk), .i_Reset_n(rstN), .i_ReqValid(reqValid), .o_ReqReady(reqReady[0]),
    .i_ReqAddress(reqAddr), .o_RespValid(respValid[0]), .i_RespReady(respReady),
    .o_RespData(respData[0]), .o_RespAddress(respAddr[0]), .o_RespError(respError[0]),
    .i_Flush(flush), .i_WrEnable(wrEn), .i_WrAddress(wrAddr), .i_WrData(wrData)
  );

  instr_mem_responder #(.DEPTH_WORDS(Depth1), .WAIT_STATES(0)) u_dut1 (
    .i_Clock(clk), .i_Reset_n(rstN), .i_ReqValid(reqValid), .o_ReqReady(reqReady[1]),
    .i_ReqAddress(reqAddr), .o_RespValid(respValid[1]), .i_RespReady(respReady),
    .o_RespData(respData[1]), .o_RespAddress(respAddr[1]), .o_RespError(respError[1]),
    .i_Flush(flush), .i_WrEnable(wrEn), .i_WrAddress(wrAddr), .i_WrData(wrData)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit isErr(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || (32'(a[31:2]) >= depth);
  endfunction

  function automatic int unsigned waitsOf(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int unsigned depthOf(input int d);
    return (d == 0) ? Depth0 : Depth1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mBusy[d] = 0; mValid[d] = 0; mPend[d] = '0;
      mData[d] = '0; mAddr[d] = '0; mErr[d] = 0;
    end
  endtask

  // One clock edge worth of behaviour, applied using the inputs about to be sampled.
  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      bit rdy;
      rdy = !mBusy[d] || (mValid[d] && respReady);
      if (flush) begin
        mBusy[d] = 0; mValid[d] = 0;
      end else begin
        if (mValid[d] && respReady) begin
          mBusy[d] = 0; mValid[d] = 0;
        end
        if (reqValid && rdy) begin
          mBusy[d] = 1; mValid[d] = 0; mPend[d] = reqAddr; mDue[d] = edgeNo + waitsOf(d);
        end
        if (mBusy[d] && !mValid[d] && edgeNo == mDue[d]) begin
          mValid[d] = 1;
          mAddr[d]  = mPend[d];
          mErr[d]   = isErr(mPend[d], depthOf(d));
          mData[d]  = mErr[d] ? 32'h0000_0013 : refMem[mPend[d][11:2]];
        end
      end
    end
    if (wrEn && !isErr(wrAddr, Depth0)) refMem[wrAddr[11:2]] = wrData;
    edgeNo++;
  endtask

  task automatic runCycle(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                          input bit we, input logic [31:0] wa, input logic [31:0] wd);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkVal($sformatf("respValid%0d", d), respValid[d], mValid[d]);
      checkVal($sformatf("respData%0d", d), respData[d], mData[d]);
      checkVal($sformatf("respAddr%0d", d), respAddr[d], mAddr[d]);
      checkVal($sformatf("respError%0d", d), respError[d], mErr[d]);
    end
    reqValid = rv; reqAddr = ra; respReady = rr; flush = fl;
    wrEn = we; wrAddr = wa; wrData = wd;
    #1;
    for (int d = 0; d < 2; d++)
      checkVal($sformatf("reqReady%0d", d), reqReady[d], !mBusy[d] || (mValid[d] && rr));
    modelStep();
  endtask

  task automatic idle(input bit rr, input int n);
    for (int i = 0; i < n; i++) runCycle(0, 32'd0, rr, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkVal({tag, "Valid"}, respValid[d], 32'd0);
      checkVal({tag, "Ready"}, reqReady[d], 32'd0);
      checkVal({tag, "Data"}, respData[d], 32'd0);
      checkVal({tag, "Addr"}, respAddr[d], 32'd0);
      checkVal({tag, "Err"}, respError[d], 32'd0);
    end
  endtask

  // Reset lands mid-cycle, after the edge the model has already accounted for.
  task automatic applyReset();
    @(posedge clk);
    #2;
    rstN = 0;
    reqValid = 0; respReady = 0; flush = 0; wrEn = 0;
    #1;
    checkResetOutputs("rstMid");
    modelReset();
    repeat (2) @(negedge clk);
    rstN = 1;
    #1;
    for (int d = 0; d < 2; d++) checkVal("readyAfterRst", reqReady[d], 32'd1);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    case ($urandom_range(7))
      0, 1, 2, 3: a = 32'($urandom_range(Depth1 - 1)) << 2;
      4, 5:       a = 32'($urandom_range(Depth0 - 1)) << 2;
      6: begin
        a      = 32'($urandom_range(Depth0 - 1)) << 2;
        a[1:0] = 2'($urandom_range(3, 1));
      end
      default:    a = 32'($urandom_range(Depth0 + 15, Depth0)) << 2;
    endcase
    return a;
  endfunction

  initial begin
    rstN = 0;
    reqValid = 0; reqAddr = '0; respReady = 0; flush = 0;
    wrEn = 0; wrAddr = '0; wrData = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("rstInit");
    rstN = 1;
    #1;
    for (int d = 0; d < 2; d++) checkVal("readyAfterRst", reqReady[d], 32'd1);

    // Program load of the whole image
    for (int i = 0; i < int'(Depth0); i++)
      runCycle(0, 32'd0, 1, 0, 1, 32'(i) << 2, $urandom());

    // Basic fetch, then three cycles of backpressure
    runCycle(0, 32'd0, 1, 0, 1, 32'd0, 32'h0050_0093);
    runCycle(1, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    idle(0, 1);
    idle(0, 1);
    checkVal("fetch0Valid", respValid[0], 32'd1);
    checkVal("fetch0Data", respData[0], 32'h0050_0093);
    checkVal("fetch0Err", respError[0], 32'd0);
    idle(0, 2);
    checkVal("holdData", respData[0], 32'h0050_0093);
    checkVal("holdReady", reqReady[0], 32'd0);
    idle(1, 2);

    // Misaligned and out-of-range fetches
    runCycle(1, 32'h0000_0006, 1, 0, 0, 32'd0, 32'd0);
    idle(1, 1);
    idle(1, 1);
    checkVal("misalignErr", respError[0], 32'd1);
    checkVal("misalignNop", respData[0], 32'h0000_0013);
    runCycle(1, 32'h0000_1000, 1, 0, 0, 32'd0, 32'd0);
    idle(1, 1);
    idle(1, 1);
    checkVal("rangeErr", respError[0], 32'd1);
    checkVal("rangeNop", respData[0], 32'h0000_0013);
    idle(1, 1);

    // Flush during the wait state, then a fresh fetch
    runCycle(1, 32'h0000_0004, 1, 0, 0, 32'd0, 32'd0);
    runCycle(0, 32'd0, 1, 1, 0, 32'd0, 32'd0);
    runCycle(1, 32'h0000_0040, 1, 0, 0, 32'd0, 32'd0);
    idle(1, 3);

    // Streamed fetches
    runCycle(1, 32'h0, 1, 0, 0, 32'd0, 32'd0);
    runCycle(1, 32'h4, 1, 0, 0, 32'd0, 32'd0);
    runCycle(1, 32'h8, 1, 0, 0, 32'd0, 32'd0);
    idle(1, 3);

    // Read-before-write on the edge that loads the response
    runCycle(1, 32'h0000_0020, 1, 0, 0, 32'd0, 32'd0);
    runCycle(0, 32'd0, 1, 0, 1, 32'h0000_0020, 32'hDEAD_BEEF);
    idle(1, 3);

    // Reset while a response is held, then refetch the same word
    runCycle(1, 32'h0000_0010, 0, 0, 0, 32'd0, 32'd0);
    idle(0, 2);
    applyReset();
    idle(1, 2);
    runCycle(1, 32'h0000_0010, 1, 0, 0, 32'd0, 32'd0);
    idle(1, 3);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599) == 0) applyReset();
      runCycle($urandom_range(3) != 0, randAddr(), $urandom_range(3) != 0,
               $urandom_range(19) == 0, $urandom_range(4) == 0,
               ($urandom_range(9) == 0) ? randAddr() : 32'($urandom_range(Depth1 - 1)) << 2,
               $urandom());
    end
    idle(1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between request acceptance and response (0..7).
REQ-003 SHALL have port i_Clock, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port i_Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_ReqValid, input, 1 bit: fetch request present.
REQ-006 SHALL have port o_ReqReady, output, 1 bit: request can be accepted this cycle.
REQ-007 SHALL have port i_ReqAddress, input, 32 bits: byte address of the fetch.
REQ-008 SHALL have port o_RespValid, output, 1 bit: response present.
REQ-009 SHALL have port i_RespReady, input, 1 bit: consumer takes the response.
REQ-010 SHALL have port o_RespData, output, 32 bits: instruction word.
REQ-011 SHALL have port o_RespAddress, output, 32 bits: echoed request address.
REQ-012 SHALL have port o_RespError, output, 1 bit: misaligned or out-of-range fetch.
REQ-013 SHALL have port i_Flush, input, 1 bit: branch taken; discard any outstanding fetch.
REQ-014 SHALL have port i_WrEnable, input, 1 bit: program-load write strobe.
REQ-015 SHALL have port i_WrAddress, input, 32 bits: byte address of the program-load write.
REQ-016 SHALL have port i_WrData, input, 32 bits: program-load write data.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL drive o_ReqReady=1 in IDLE, and in RESP when i_RespReady=1; 0 otherwise.
REQ-019 SHALL accept a request on an edge where i_ReqValid & o_ReqReady & !i_Flush, latching the address.
REQ-020 On acceptance, SHALL go to WAIT with the wait counter loaded to WAIT_STATES-1, or directly to RESP when WAIT_STATES=0.
REQ-021 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-022 Response latency SHALL be WAIT_STATES+1 cycles from acceptance edge to o_RespValid=1.
REQ-023 SHALL assert o_RespValid only in RESP.
REQ-024 SHALL hold o_RespData, o_RespAddress and o_RespError stable while o_RespValid & !i_RespReady.
REQ-025 On RESP with i_RespReady=1, SHALL go to IDLE, or to WAIT/RESP per REQ-020 if a new request is accepted on the same edge (back-to-back, throughput 1 per WAIT_STATES+1 cycles).
REQ-026 o_RespError SHALL be 1 when address[1:0]!=0 or address[31:2]>=DEPTH_WORDS.
REQ-027 When o_RespError=1, o_RespData SHALL be 0x00000013 (NOP); otherwise o_RespData SHALL be mem[address[31:2]].
REQ-028 Response data SHALL be read from memory on the edge entering RESP, read-before-write; a write on that same edge is not visible.
REQ-029 i_Flush=1 SHALL force IDLE on the next edge from any state, dropping o_RespValid and suppressing acceptance that cycle.
REQ-030 i_WrEnable SHALL write mem[i_WrAddress[31:2]] on the edge; out-of-range or misaligned writes SHALL be ignored; writes SHALL be allowed in any state.

Reset
REQ-031 i_Reset_n=0 SHALL asynchronously force IDLE, counter=0, o_RespValid=0, o_RespError=0, o_RespData=0, o_RespAddress=0; o_ReqReady SHALL be 0 while reset is held and 1 in the first cycle after release.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted mid-WAIT or mid-RESP SHALL discard the outstanding fetch; no response SHALL appear after release without a new request.

Verification
REQ-034 With WAIT_STATES=1: load mem[0]=0x00500093, request 0x0 at cycle 0 -> o_RespValid at cycle 2, data 0x00500093, address 0x0, error 0.
REQ-035 Backpressure: i_RespReady=0 for 3 cycles -> RespValid/Data/Address held constant; o_ReqReady=0; response completes on the first cycle i_RespReady=1.
REQ-036 Errors: request 0x00000006 -> error 1, data 0x00000013; request 0x00001000 with DEPTH_WORDS=1024 -> error 1, data 0x00000013.
REQ-037 Flush: accept 0x4, assert i_Flush in WAIT -> no response; request 0x40 next cycle -> response for 0x40 only.
REQ-038 Back-to-back: WAIT_STATES=0, i_RespReady=1, requests 0x0,0x4,0x8 streamed -> one response per cycle, in order.
REQ-039 Reset mid-RESP: drop i_Reset_n while o_RespValid=1 -> o_RespValid=0 immediately; memory contents unchanged after release.
